// File: rtl/hazard_ctrl_if.sv
// Control-word package and hazard controller bus.
// The datapath drives the decoded fields and cache handshakes through the
// master modport. It receives the control word, the PC enable and the
// completion masks. hazard_ctrl sits on the slave modport.
package control_itf;
  typedef struct packed {
    logic [1:0] rs1mux_sel;
    logic [1:0] rs2mux_sel;
    logic       pipe_load_ifid;
    logic       pipe_load_idex;
    logic       pipe_load_exmem;
    logic       pipe_load_memwb;
    logic       pipe_rst_ifid;
    logic       pipe_rst_idex;
    logic       pipe_rst_exmem;
    logic       pipe_rst_memwb;
  } control;
endpackage

interface hazard_ctrl_if;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic [4:0]          ex_rs1;
  logic [4:0]          ex_rs2;
  logic [4:0]          ex_rd;
  logic                ex_load_regfile;
  logic                ex_dcache_read;
  logic [4:0]          mem_rd;
  logic                mem_load_regfile;
  logic [4:0]          wb_rd;
  logic                wb_load_regfile;
  logic                br_taken;
  logic                icache_read;
  logic                icache_resp;
  logic                mem_dcache_read;
  logic                mem_dcache_write;
  logic                dcache_resp;
  control_itf::control ctrl;
  logic                load_pc;
  logic                icache_mask;
  logic                dcache_mask;

  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_load_regfile, ex_dcache_read,
    output mem_rd, mem_load_regfile, wb_rd, wb_load_regfile, br_taken,
    output icache_read, icache_resp, mem_dcache_read, mem_dcache_write, dcache_resp,
    input  ctrl, load_pc, icache_mask, dcache_mask
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_load_regfile, ex_dcache_read,
    input  mem_rd, mem_load_regfile, wb_rd, wb_load_regfile, br_taken,
    input  icache_read, icache_resp, mem_dcache_read, mem_dcache_write, dcache_resp,
    output ctrl, load_pc, icache_mask, dcache_mask
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32I core.
// It produces the forwarding selects and the per-register load/reset strobes.
// It remembers which half of a split I/D miss has already completed, so that
// response is not lost while the pipeline stays frozen for the other half.
// Build option: HAZARD_FORWARDING_EN enables EX/MEM and MEM/WB forwarding.
// With forwarding, the only data stall is the load-use bubble. Without it,
// the selects are tied to 0 and RAW dependences on EX and MEM stall instead.
module hazard_ctrl (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  logic                i_done, d_done;
  logic                i_done_nxt, d_done_nxt;
  logic                i_pend, d_pend, freeze;
  logic                stall;
  logic [1:0]          rs1_sel, rs2_sel;
  control_itf::control ctrl_w;

`ifdef HAZARD_FORWARDING_EN
  // EX/MEM wins over MEM/WB. x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       mem_ld, input logic [4:0] mem_rd,
                                         input logic       wb_ld,  input logic [4:0] wb_rd);
    if (mem_ld && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'd1;
    else if (wb_ld && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'd2;
    else
      return 2'd0;
  endfunction
`else
  // A nonzero destination of a stage that writes the regfile, matched by an ID source.
  function automatic logic raw_hit(input logic ld, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
    return ld && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction
`endif

  // Outstanding misses: a request without a response that has not already completed
  always_comb begin
    i_pend = bus.icache_read && !bus.icache_resp && !i_done;
    d_pend = (bus.mem_dcache_read || bus.mem_dcache_write) && !bus.dcache_resp && !d_done;
    freeze = i_pend || d_pend;
  end

  // State register: completion bits; reset discards any held completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      i_done <= i_done_nxt;
      d_done <= d_done_nxt;
    end
  end

  // Next state: latch a response that arrives while the other side still misses; clear on advance
  always_comb begin
    i_done_nxt = 1'b0;
    d_done_nxt = 1'b0;
    if (freeze) begin
      i_done_nxt = i_done || (bus.icache_resp && d_pend);
      d_done_nxt = d_done || (bus.dcache_resp && i_pend);
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // Forwarding selects for the EX operands, and load-use detection against ID
  always_comb begin
    rs1_sel = fwd_sel(bus.ex_rs1, bus.mem_load_regfile, bus.mem_rd,
                      bus.wb_load_regfile, bus.wb_rd);
    rs2_sel = fwd_sel(bus.ex_rs2, bus.mem_load_regfile, bus.mem_rd,
                      bus.wb_load_regfile, bus.wb_rd);
    stall   = bus.ex_dcache_read && (bus.ex_rd != 5'd0) &&
              ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  end
`else
  // No forwarding: stall on RAW against EX or MEM; WB is covered by the write-through regfile
  always_comb begin
    rs1_sel = 2'd0;
    rs2_sel = 2'd0;
    stall   = raw_hit(bus.ex_load_regfile, bus.ex_rd, bus.id_rs1, bus.id_rs2) ||
              raw_hit(bus.mem_load_regfile, bus.mem_rd, bus.id_rs1, bus.id_rs2);
  end
`endif

  // Output decode: reset, then freeze, branch, stall, advance, with the first match winning
  always_comb begin
    ctrl_w      = '0;
    bus.load_pc = 1'b0;
    if (rst) begin
      ctrl_w.pipe_rst_ifid  = 1'b1;
      ctrl_w.pipe_rst_idex  = 1'b1;
      ctrl_w.pipe_rst_exmem = 1'b1;
      ctrl_w.pipe_rst_memwb = 1'b1;
    end else begin
      ctrl_w.rs1mux_sel = rs1_sel;
      ctrl_w.rs2mux_sel = rs2_sel;
      if (freeze) begin
        ctrl_w.pipe_load_ifid = 1'b0;
      end else if (bus.br_taken) begin
        ctrl_w.pipe_load_ifid  = 1'b1;
        ctrl_w.pipe_load_idex  = 1'b1;
        ctrl_w.pipe_load_exmem = 1'b1;
        ctrl_w.pipe_load_memwb = 1'b1;
        ctrl_w.pipe_rst_ifid   = 1'b1;
        ctrl_w.pipe_rst_idex   = 1'b1;
        bus.load_pc            = 1'b1;
      end else if (stall) begin
        ctrl_w.pipe_load_idex  = 1'b1;
        ctrl_w.pipe_load_exmem = 1'b1;
        ctrl_w.pipe_load_memwb = 1'b1;
        ctrl_w.pipe_rst_idex   = 1'b1;
      end else begin
        ctrl_w.pipe_load_ifid  = 1'b1;
        ctrl_w.pipe_load_idex  = 1'b1;
        ctrl_w.pipe_load_exmem = 1'b1;
        ctrl_w.pipe_load_memwb = 1'b1;
        bus.load_pc            = 1'b1;
      end
    end
    bus.ctrl        = ctrl_w;
    bus.icache_mask = !rst && i_done;
    bus.dcache_mask = !rst && d_done;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// Each step drives one cycle of stimulus and pushes the expected output word.
// The word is popped and compared on the following falling edge.
// Expectations follow the build option HAZARD_FORWARDING_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int K_NORM = 0;
  localparam int K_FRZ  = 1;
  localparam int K_BUB  = 2;
  localparam int K_BR   = 3;
  localparam int K_RST  = 4;

  typedef struct {
    string       tag;
    logic [14:0] v;
  } sb_item_t;

  logic          clk;
  logic          rst;
  hazard_ctrl_if hif ();
  sb_item_t      sb[$];
  int            total;
  int            bad;

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {ctrl, load_pc, icache_mask, dcache_mask} for one cycle
  function automatic logic [14:0] ew(input logic [1:0] s1, input logic [1:0] s2,
                                     input int kind, input logic im, input logic dm);
    control_itf::control c;
    logic lpc;
    c   = '0;
    lpc = 1'b0;
    c.rs1mux_sel = s1;
    c.rs2mux_sel = s2;
    case (kind)
      K_NORM: begin
        c.pipe_load_ifid = 1'b1; c.pipe_load_idex = 1'b1;
        c.pipe_load_exmem = 1'b1; c.pipe_load_memwb = 1'b1;
        lpc = 1'b1;
      end
      K_BUB: begin
        c.pipe_load_idex = 1'b1; c.pipe_load_exmem = 1'b1; c.pipe_load_memwb = 1'b1;
        c.pipe_rst_idex = 1'b1;
      end
      K_BR: begin
        c.pipe_load_ifid = 1'b1; c.pipe_load_idex = 1'b1;
        c.pipe_load_exmem = 1'b1; c.pipe_load_memwb = 1'b1;
        c.pipe_rst_ifid = 1'b1; c.pipe_rst_idex = 1'b1;
        lpc = 1'b1;
      end
      K_RST: begin
        c.rs1mux_sel = 2'd0; c.rs2mux_sel = 2'd0;
        c.pipe_rst_ifid = 1'b1; c.pipe_rst_idex = 1'b1;
        c.pipe_rst_exmem = 1'b1; c.pipe_rst_memwb = 1'b1;
      end
      default: ;
    endcase
    return {c, lpc, im, dm};
  endfunction

  task automatic idle();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0;
    hif.ex_rs1 = 5'd0; hif.ex_rs2 = 5'd0; hif.ex_rd = 5'd0;
    hif.ex_load_regfile = 1'b0; hif.ex_dcache_read = 1'b0;
    hif.mem_rd = 5'd0; hif.mem_load_regfile = 1'b0;
    hif.wb_rd = 5'd0; hif.wb_load_regfile = 1'b0;
    hif.br_taken = 1'b0;
    hif.icache_read = 1'b1; hif.icache_resp = 1'b1;
    hif.mem_dcache_read = 1'b0; hif.mem_dcache_write = 1'b0; hif.dcache_resp = 1'b0;
  endtask

  // Queue the expectation for the current stimulus and check it on the falling edge
  task automatic cyc(input string tag, input logic [14:0] e);
    sb_item_t it;
    logic [14:0] obs;
    it.tag = tag;
    it.v   = e;
    sb.push_back(it);
    @(negedge clk);
    obs = {hif.ctrl, hif.load_pc, hif.icache_mask, hif.dcache_mask};
    it  = sb.pop_front();
    chk(it.tag, {17'd0, obs}, {17'd0, it.v});
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Reset holds everything even with a live forwarding match
    hif.ex_rs1 = 5'd1; hif.mem_rd = 5'd1; hif.mem_load_regfile = 1'b1;
    cyc("reset_state", ew(0, 0, K_RST, 0, 0));
    rst = 1'b0;
    idle();
    cyc("idle_advance", ew(0, 0, K_NORM, 0, 0));

    // addi x1 ; add x2,x1,x1
    idle();
    hif.id_rs1 = 5'd1; hif.id_rs2 = 5'd1; hif.ex_rd = 5'd1; hif.ex_load_regfile = 1'b1;
    cyc("raw_id", ew(0, 0, FWD ? K_NORM : K_BUB, 0, 0));
    idle();
    if (FWD) begin
      hif.ex_rs1 = 5'd1; hif.ex_rs2 = 5'd1;
      hif.mem_rd = 5'd1; hif.mem_load_regfile = 1'b1;
      cyc("raw_fwd_ex", ew(1, 1, K_NORM, 0, 0));
    end else begin
      hif.id_rs1 = 5'd1; hif.id_rs2 = 5'd1;
      hif.mem_rd = 5'd1; hif.mem_load_regfile = 1'b1;
      cyc("raw_stall2", ew(0, 0, K_BUB, 0, 0));
      idle();
      hif.id_rs1 = 5'd1; hif.id_rs2 = 5'd1;
      hif.wb_rd = 5'd1; hif.wb_load_regfile = 1'b1;
      cyc("raw_wb_nostall", ew(0, 0, K_NORM, 0, 0));
    end

    // lw x3 ; add x4,x3,x0
    idle();
    hif.id_rs1 = 5'd3; hif.ex_rd = 5'd3; hif.ex_dcache_read = 1'b1; hif.ex_load_regfile = 1'b1;
    cyc("lu_bubble", ew(0, 0, K_BUB, 0, 0));
    idle();
    hif.id_rs1 = 5'd3; hif.mem_rd = 5'd3; hif.mem_load_regfile = 1'b1;
    cyc("lu_after", ew(0, 0, FWD ? K_NORM : K_BUB, 0, 0));
    idle();
    hif.ex_rs1 = 5'd3; hif.wb_rd = 5'd3; hif.wb_load_regfile = 1'b1;
    cyc("lu_fwd_wb", ew(FWD ? 2'd2 : 2'd0, 0, K_NORM, 0, 0));

    // Forwarding priority and x0
    idle();
    hif.ex_rs1 = 5'd5; hif.mem_rd = 5'd5; hif.mem_load_regfile = 1'b1;
    hif.wb_rd = 5'd5; hif.wb_load_regfile = 1'b1;
    cyc("fwd_prio", ew(FWD ? 2'd1 : 2'd0, 0, K_NORM, 0, 0));
    idle();
    hif.ex_rs2 = 5'd5; hif.wb_rd = 5'd5; hif.wb_load_regfile = 1'b1;
    cyc("fwd_rs2_wb", ew(0, FWD ? 2'd2 : 2'd0, K_NORM, 0, 0));
    idle();
    hif.mem_load_regfile = 1'b1; hif.wb_load_regfile = 1'b1;
    cyc("fwd_x0", ew(0, 0, K_NORM, 0, 0));
    idle();
    hif.ex_dcache_read = 1'b1; hif.ex_load_regfile = 1'b1;
    cyc("lu_x0", ew(0, 0, K_NORM, 0, 0));

    // Branch beats load-use
    idle();
    hif.br_taken = 1'b1; hif.id_rs1 = 5'd7; hif.ex_rd = 5'd7;
    hif.ex_dcache_read = 1'b1; hif.ex_load_regfile = 1'b1;
    cyc("br_lu", ew(0, 0, K_BR, 0, 0));

    // Split miss: icache response at cycle 3, dcache response at cycle 7
    for (int c = 0; c < 9; c++) begin
      idle();
      hif.icache_resp     = (c == 3) || (c == 8);
      hif.mem_dcache_read = (c < 8);
      hif.dcache_resp     = (c == 7);
      if (c == 5) begin
        hif.br_taken = 1'b1; hif.id_rs1 = 5'd2; hif.ex_rd = 5'd2;
        hif.ex_dcache_read = 1'b1; hif.ex_load_regfile = 1'b1;
      end
      cyc($sformatf("split_c%0d", c),
          ew(0, 0, (c < 7) ? K_FRZ : K_NORM, (c >= 4) && (c <= 7), 0));
    end

    // Both responses in one cycle: advance, nothing remembered
    idle();
    hif.mem_dcache_write = 1'b1; hif.dcache_resp = 1'b1;
    cyc("both_resp", ew(0, 0, K_NORM, 0, 0));
    idle();
    hif.icache_resp = 1'b0; hif.mem_dcache_write = 1'b1;
    cyc("both_miss", ew(0, 0, K_FRZ, 0, 0));
    idle();
    hif.mem_dcache_write = 1'b1; hif.dcache_resp = 1'b1;
    cyc("both_resp2", ew(0, 0, K_NORM, 0, 0));

    // Reset while d_done is held
    idle();
    hif.icache_resp = 1'b0; hif.mem_dcache_read = 1'b1; hif.dcache_resp = 1'b1;
    cyc("rf_dresp", ew(0, 0, K_FRZ, 0, 0));
    hif.dcache_resp = 1'b0;
    cyc("rf_ddone", ew(0, 0, K_FRZ, 0, 1));
    rst = 1'b1;
    cyc("rf_rst_now", ew(0, 0, K_RST, 0, 0));
    cyc("rf_rst_hold", ew(0, 0, K_RST, 0, 0));
    rst = 1'b0;
    cyc("rf_reissue", ew(0, 0, K_FRZ, 0, 0));
    hif.icache_resp = 1'b1; hif.dcache_resp = 1'b1;
    cyc("rf_done", ew(0, 0, K_NORM, 0, 0));

    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It produces the `control_itf::control` word that the datapath consumes: forwarding mux selects (`rs1mux_sel`, `rs2mux_sel`) plus the per-register load and reset strobes for IF/ID, ID/EX, EX/MEM and MEM/WB. Its inputs are the decoded register fields, the ctrl_word bits of each stage, the branch resolution and the I/D cache handshakes. It holds memory-completion state so that split I/D cache responses are never lost while the pipeline is frozen.

## Interface
Parameters
- none

Ports
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- ex_rs1, ex_rs2, ex_rd  in  5 each  register fields from ID/EX
- ex_load_regfile, ex_dcache_read  in  1 each  ID/EX ctrl_word bits
- mem_rd  in  5  rd from EX/MEM
- mem_load_regfile  in  1  EX/MEM ctrl_word bit
- wb_rd  in  5  rd from MEM/WB
- wb_load_regfile  in  1  MEM/WB ctrl_word bit
- br_taken  in  1  branch/jump redirect resolved in EX
- icache_read, icache_resp  in  1 each  fetch request and response
- mem_dcache_read, mem_dcache_write, dcache_resp  in  1 each  MEM-stage request and response
- ctrl  out  control_itf::control  `rs1mux_sel`, `rs2mux_sel`, `pipe_load_*`, `pipe_rst_*`
- load_pc  out  1  PC register enable
- icache_mask, dcache_mask  out  1 each  request has already completed this cycle group; the datapath suppresses re-issue and uses its held response data

## Operation
- Mux encoding: 0 = ID/EX register value, 1 = EX/MEM ALU result, 2 = MEM/WB writeback value, 3 = reserved and never driven.
- Forwarding for rsN: select 1 if `mem_load_regfile` && `mem_rd != 0` && `mem_rd == ex_rsN`. Otherwise select 2 if the same test holds for WB. Otherwise select 0. EX/MEM has priority over MEM/WB.
- State: two bits, `i_done` and `d_done`.
- `i_pend` = `icache_read` && !`icache_resp` && !`i_done`.
- `d_pend` = (`mem_dcache_read` || `mem_dcache_write`) && !`dcache_resp` && !`d_done`.
- `freeze` = `i_pend` || `d_pend`.
- Done bits:
  - `i_done` sets on `icache_resp` while `d_pend`.
  - `d_done` sets on `dcache_resp` while `i_pend`.
  - Both clear on any cycle with !`freeze`.
- `icache_mask` = `i_done`. `dcache_mask` = `d_done`.
- Load-use: `lu` = `ex_dcache_read` && `ex_rd != 0` && (`ex_rd == id_rs1` || `ex_rd == id_rs2`).
- Per-cycle priority (first match wins):
  - `freeze`: all `pipe_load_*` = 0, `load_pc` = 0, all `pipe_rst_*` = 0. `br_taken` and `lu` are ignored.
  - `br_taken`: all loads = 1, `load_pc` = 1, `pipe_rst_ifid` = 1, `pipe_rst_idex` = 1. This squashes the two younger instructions.
  - `lu`: `load_pc` = 0, `pipe_load_ifid` = 0, `pipe_rst_idex` = 1 (bubble), EX/MEM and MEM/WB load = 1.
  - Otherwise: all loads = 1, all resets = 0.
- x0 is never a hazard source.

## Timing
- All outputs are combinational from inputs and the done bits.
- No added latency on the advance path: a response that arrives with no other pending miss advances the pipeline in the same cycle.
- Load-use costs exactly 1 bubble. The following cycle forwards through select 2.
- Split miss: the pipeline advances in the cycle the later response arrives. The done bits clear at that edge.
- Reset, while `rst` is asserted:
  - `i_done` = `d_done` = 0
  - all `pipe_load_*` = 0, all `pipe_rst_*` = 1, `load_pc` = 0
  - mux selects = 0, masks = 0
- Reset asserted mid-freeze discards done bits. The cache requests are re-issued after reset.
- `br_taken` together with `lu`: branch wins and no bubble is inserted.
- `icache_resp` and `dcache_resp` in the same cycle: advance, and neither done bit sets.

## Configuration
- `HAZARD_FORWARDING_EN` defined: forwarding as above. The only data-hazard stall is the 1-cycle load-use bubble.
- Not defined:
  - `rs1mux_sel` and `rs2mux_sel` are tied to 0.
  - `lu` is replaced by a RAW test: ID rs matches a nonzero `ex_rd` with `ex_load_regfile`, or a nonzero `mem_rd` with `mem_load_regfile`.
  - The RAW stall inserts bubbles using the same outputs as `lu`.
  - The regfile is write-through, so a WB match does not stall.
  - Stall is up to 2 cycles per dependence.

## Test plan
- `addi x1`, then `add x2,x1,x1` back-to-back with forwarding -> `rs1mux_sel` = `rs2mux_sel` = 1 in the add's EX cycle, no stall. Without the macro -> 2 bubbles and selects held at 0.
- `lw x3`, then `add x4,x3,x0` -> 1 cycle with `pipe_load_ifid` = 0, `pipe_rst_idex` = 1, `load_pc` = 0. The next cycle shows `rs1mux_sel` = 2.
- Forwarding priority: x5 written by both EX/MEM and MEM/WB with `ex_rs1` = 5 -> `rs1mux_sel` = 1. With rd = 0 in both -> select 0.
- Split miss: `icache_resp` at cycle 3, `dcache_resp` at cycle 7:
  - `icache_mask` = 1 in cycles 4-7.
  - All loads = 0 through cycle 6 and = 1 in cycle 7.
  - Masks = 0 in cycle 8.
- `br_taken` together with `lu` -> `pipe_rst_ifid` = `pipe_rst_idex` = 1 and `load_pc` = 1. The same `br_taken` during a freeze -> no reset, all loads 0.
- Assert `rst` while `d_done` = 1 -> `d_done` = 0 immediately, all `pipe_rst_*` = 1, `pipe_load_*` = 0 until release.
